// File: rtl/dmi_timeout_shim.sv
// dmi_timeout_shim
//
// Sits between the DMI transport master and the Debug Module DMI slave.
// Requests are buffered in a small FIFO, and only one transaction is ever
// outstanding at the Debug Module. NOP and reserved ops are answered
// locally. If the DM does not answer a READ/WRITE within TIMEOUT_CYCLES
// cycles, a FAILED response is synthesised so that a hung DM cannot stall
// the host. The late answer that eventually arrives for that abandoned
// transaction is consumed and dropped.
//
// Ports
//   clk, reset_n           clock; synchronous active-low reset
//   dtm_req_*              request channel from the transport (valid/ready)
//   dtm_resp_*             response channel to the transport (valid/ready)
//   dm_req_*               request channel to the Debug Module (valid/ready)
//   dm_resp_*              response channel from the Debug Module (valid/ready)
//   timeout_seen           sticky flag, set on the first timeout
//   dbg_state              current FSM state, for observation only
//
// Handshake rule on every channel: a transfer happens on a rising clock
// edge where valid and ready are both 1. A source holds valid and its
// payload stable until that transfer; a sink may change ready freely.
//
// Op codes:   0=NOP 1=READ 2=WRITE 3=reserved
// Resp codes: 0=OK  2=FAILED 3=BUSY

module dmi_timeout_shim #(
    parameter int ADDR_BITS      = 7,
    parameter int REQ_DEPTH      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 dtm_req_valid,
    output logic                 dtm_req_ready,
    input  logic [ADDR_BITS-1:0] dtm_req_addr,
    input  logic [1:0]           dtm_req_op,
    input  logic [31:0]          dtm_req_data,

    output logic                 dtm_resp_valid,
    input  logic                 dtm_resp_ready,
    output logic [1:0]           dtm_resp_resp,
    output logic [31:0]          dtm_resp_data,

    output logic                 dm_req_valid,
    input  logic                 dm_req_ready,
    output logic [ADDR_BITS-1:0] dm_req_addr,
    output logic [1:0]           dm_req_op,
    output logic [31:0]          dm_req_data,

    input  logic                 dm_resp_valid,
    output logic                 dm_resp_ready,
    input  logic [1:0]           dm_resp_resp,
    input  logic [31:0]          dm_resp_data,

    output logic                 timeout_seen,
    output logic [1:0]           dbg_state
);

    localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    // With the timeout disabled the timer is unused; keep it one bit wide.
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_RSVD = 2'd3;
    localparam logic [1:0] RESP_OK     = 2'd0;
    localparam logic [1:0] RESP_FAILED = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [ADDR_BITS-1:0] fifo_addr [REQ_DEPTH];
    logic [1:0]           fifo_op   [REQ_DEPTH];
    logic [31:0]          fifo_data [REQ_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [ADDR_BITS-1:0] head_addr;
    logic [1:0]           head_op;
    logic [31:0]          head_data;

    logic [TMR_W-1:0]     timer;
    // Set when a transaction was abandoned by timeout: the DM still owes
    // one response, which must be swallowed before anything new is issued.
    logic                 stale;

    assign fifo_full     = (count == CNT_W'(REQ_DEPTH));
    assign fifo_empty    = (count == '0);
    // No bypass: a full FIFO refuses even if it pops in the same cycle.
    assign dtm_req_ready = !fifo_full;
    assign push          = dtm_req_valid && !fifo_full;

    assign head_addr = fifo_addr[rd_ptr];
    assign head_op   = fifo_op[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // Local ops leave the FIFO straight from IDLE; DM ops leave it only
    // when the DM accepts them, so the head stays valid while ISSUE waits.
    always_comb begin
        pop = 1'b0;
        case (state)
            S_IDLE:  pop = !fifo_empty && !stale &&
                           (head_op == OP_NOP || head_op == OP_RSVD);
            S_ISSUE: pop = dm_req_ready;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= dtm_req_addr;
            fifo_op[wr_ptr]   <= dtm_req_op;
            fifo_data[wr_ptr] <= dtm_req_data;
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    assign dm_resp_ready = (state == S_WAIT) || stale;
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            timer          <= '0;
            stale          <= 1'b0;
            timeout_seen   <= 1'b0;
            dm_req_valid   <= 1'b0;
            dm_req_addr    <= '0;
            dm_req_op      <= '0;
            dm_req_data    <= '0;
            dtm_resp_valid <= 1'b0;
            dtm_resp_resp  <= '0;
            dtm_resp_data  <= '0;
        end else begin
            // The first DM response seen while stale belongs to the
            // abandoned transaction; it is dropped here. stale is never 1
            // in WAIT, so this cannot collide with the timeout below.
            if (stale && dm_resp_valid) stale <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!fifo_empty && !stale) begin
                        case (head_op)
                            OP_NOP: begin
                                dtm_resp_valid <= 1'b1;
                                dtm_resp_resp  <= RESP_OK;
                                dtm_resp_data  <= '0;
                                state          <= S_RESP;
                            end
                            OP_RSVD: begin
                                dtm_resp_valid <= 1'b1;
                                dtm_resp_resp  <= RESP_FAILED;
                                dtm_resp_data  <= '0;
                                state          <= S_RESP;
                            end
                            default: begin
                                dm_req_valid <= 1'b1;
                                dm_req_addr  <= head_addr;
                                dm_req_op    <= head_op;
                                dm_req_data  <= head_data;
                                state        <= S_ISSUE;
                            end
                        endcase
                    end
                end

                S_ISSUE: begin
                    if (dm_req_ready) begin
                        dm_req_valid <= 1'b0;
                        timer        <= '0;
                        state        <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (timer != TMR_MAX) timer <= timer + TMR_W'(1);
                    // A real response always beats a timeout in the same cycle.
                    if (dm_resp_valid) begin
                        dtm_resp_valid <= 1'b1;
                        dtm_resp_resp  <= dm_resp_resp;
                        dtm_resp_data  <= dm_resp_data;
                        state          <= S_RESP;
                    end else if (TIMEOUT_CYCLES != 0 && timer == TMR_LAST) begin
                        dtm_resp_valid <= 1'b1;
                        dtm_resp_resp  <= RESP_FAILED;
                        dtm_resp_data  <= '0;
                        stale          <= 1'b1;
                        timeout_seen   <= 1'b1;
                        state          <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (dtm_resp_ready) begin
                        dtm_resp_valid <= 1'b0;
                        state          <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_timeout_shim.sv
// Bench for dmi_timeout_shim: directed scenarios followed by a random phase,
// all checked against a transaction-level model of the shim.

module tb_dmi_timeout_shim;

    localparam int AB    = 7;
    localparam int DEPTH = 2;
    localparam int TO    = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic          dtm_req_valid, dtm_req_ready;
    logic [AB-1:0] dtm_req_addr;
    logic [1:0]    dtm_req_op;
    logic [31:0]   dtm_req_data;
    logic          dtm_resp_valid, dtm_resp_ready;
    logic [1:0]    dtm_resp_resp;
    logic [31:0]   dtm_resp_data;
    logic          dm_req_valid, dm_req_ready;
    logic [AB-1:0] dm_req_addr;
    logic [1:0]    dm_req_op;
    logic [31:0]   dm_req_data;
    logic          dm_resp_valid, dm_resp_ready;
    logic [1:0]    dm_resp_resp;
    logic [31:0]   dm_resp_data;
    logic          timeout_seen;
    logic [1:0]    dbg_state;

    dmi_timeout_shim #(.ADDR_BITS(AB), .REQ_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready),
        .dtm_req_addr(dtm_req_addr), .dtm_req_op(dtm_req_op), .dtm_req_data(dtm_req_data),
        .dtm_resp_valid(dtm_resp_valid), .dtm_resp_ready(dtm_resp_ready),
        .dtm_resp_resp(dtm_resp_resp), .dtm_resp_data(dtm_resp_data),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
        .dm_req_addr(dm_req_addr), .dm_req_op(dm_req_op), .dm_req_data(dm_req_data),
        .dm_resp_valid(dm_resp_valid), .dm_resp_ready(dm_resp_ready),
        .dm_resp_resp(dm_resp_resp), .dm_resp_data(dm_resp_data),
        .timeout_seen(timeout_seen), .dbg_state(dbg_state)
    );

    // ---------------- model state ----------------
    typedef struct packed { logic [AB-1:0] addr; logic [1:0] op; logic [31:0] data; } req_t;
    typedef struct packed { logic [7:0] dly; logic [1:0] resp; logic [31:0] data; } dmf_t;

    req_t        stim_q[$];    // directed requests waiting to be driven
    req_t        req_q[$];     // accepted requests, awaiting transport response (order)
    req_t        dm_exp_q[$];  // READ/WRITE requests expected at the DM, in order
    logic [33:0] exp_q[$];     // {resp,data} outcome of each DM transaction
    dmf_t        force_q[$];   // directed DM behaviour (delay/resp/data)

    req_t        cur_req;
    int          n_checks = 0, n_pass = 0;
    int          acc_cnt = 0, dm_iss_cnt = 0;
    int          rr_pct = 100;
    bit          rand_en = 0, dm_rdy_en = 1;
    bit          exp_ts = 0;
    bit          dm_busy = 0;
    int          dm_cnt = 0;
    logic [1:0]  dm_r;
    logic [31:0] dm_d;
    bit          hold_resp = 0, hold_req = 0;
    logic [33:0] held_resp;
    logic [40:0] held_req;
    bit          mon_dtm_resp_valid, mon_dm_req_valid, mon_dm_req_hs, mon_dm_resp_hs, mon_req_acc;

    int          delay_tab[10] = '{0, 1, 2, 3, 5, 14, 15, 16, 17, 22};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- monitor + model (runs at negedge) ----------------
    task automatic monitor();
        req_t        e;
        dmf_t        f;
        logic [33:0] x;
        mon_dtm_resp_valid = dtm_resp_valid;
        mon_dm_req_valid   = dm_req_valid;
        mon_dm_req_hs      = dm_req_valid && dm_req_ready;
        mon_dm_resp_hs     = dm_resp_valid && dm_resp_ready;
        mon_req_acc        = dtm_req_valid && dtm_req_ready;

        if (hold_resp) check("dtm_resp_hold", {dtm_resp_valid, dtm_resp_resp, dtm_resp_data}, {1'b1, held_resp});
        if (hold_req)  check("dm_req_hold", {dm_req_valid, dm_req_addr, dm_req_op, dm_req_data}, {1'b1, held_req});
        hold_resp = dtm_resp_valid && !dtm_resp_ready;
        held_resp = {dtm_resp_resp, dtm_resp_data};
        hold_req  = dm_req_valid && !dm_req_ready;
        held_req  = {dm_req_addr, dm_req_op, dm_req_data};

        if (mon_req_acc) begin
            acc_cnt++;
            req_q.push_back(cur_req);
            if (cur_req.op == 2'd1 || cur_req.op == 2'd2) dm_exp_q.push_back(cur_req);
        end

        if (mon_dm_resp_hs) dm_busy = 0;

        if (mon_dm_req_hs) begin
            dm_iss_cnt++;
            check("dm_one_outstanding", dm_busy, 0);
            check("dm_req_pending", dm_exp_q.size() > 0, 1);
            if (dm_exp_q.size() > 0) begin
                e = dm_exp_q.pop_front();
                check("dm_req_fields", {dm_req_addr, dm_req_op, dm_req_data}, e);
            end
            if (force_q.size() > 0) f = force_q.pop_front();
            else begin
                f.dly  = 8'(delay_tab[$urandom_range(0, 9)]);
                case ($urandom_range(0, 2))
                    0: f.resp = 2'd0;
                    1: f.resp = 2'd2;
                    default: f.resp = 2'd3;
                endcase
                f.data = $urandom;
            end
            dm_busy = 1;
            dm_cnt  = int'(f.dly);
            dm_r    = f.resp;
            dm_d    = f.data;
            // The DM answer lands in wait cycle dly+1; the shim gives up after TO cycles.
            if (int'(f.dly) + 1 <= TO) exp_q.push_back({f.resp, f.data});
            else begin
                exp_q.push_back({2'd2, 32'd0});
                exp_ts = 1;
            end
        end

        if (dtm_resp_valid && dtm_resp_ready) begin
            check("dtm_resp_pending", req_q.size() > 0, 1);
            if (req_q.size() > 0) begin
                e = req_q.pop_front();
                if (e.op == 2'd0) x = {2'd0, 32'd0};
                else if (e.op == 2'd3) x = {2'd2, 32'd0};
                else begin
                    check("dtm_resp_has_dm_outcome", exp_q.size() > 0, 1);
                    x = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h0;
                end
                check("dtm_resp", {dtm_resp_resp, dtm_resp_data}, x);
                check("timeout_seen", timeout_seen, exp_ts);
            end
        end
    endtask

    // ---------------- driver (runs just after posedge) ----------------
    task automatic drive();
        if (mon_req_acc || !dtm_req_valid) begin
            if (stim_q.size() > 0) begin
                cur_req = stim_q.pop_front();
                dtm_req_valid = 1'b1;
            end else if (rand_en && $urandom_range(0, 99) < 40) begin
                cur_req.addr = AB'($urandom_range(0, 127));
                cur_req.op   = 2'($urandom_range(0, 3));
                cur_req.data = $urandom;
                dtm_req_valid = 1'b1;
            end else dtm_req_valid = 1'b0;
            dtm_req_addr = cur_req.addr;
            dtm_req_op   = cur_req.op;
            dtm_req_data = cur_req.data;
        end
        dtm_resp_ready = ($urandom_range(0, 99) < rr_pct);
        dm_req_ready   = dm_rdy_en && ($urandom_range(0, 99) < 70);
        if (mon_dm_resp_hs) dm_resp_valid = 1'b0;
        if (dm_busy && !dm_resp_valid) begin
            if (dm_cnt == 0) begin
                dm_resp_valid = 1'b1;
                dm_resp_resp  = dm_r;
                dm_resp_data  = dm_d;
            end else dm_cnt--;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    // which: 0=dtm_resp_valid 1=dm_req_valid 2=dm_req handshake 3=dm_resp handshake 4=request accepted
    task automatic steps_until(input int which, input int max_cyc, output int k);
        bit hit;
        k = 0;
        hit = 0;
        while (!hit && k < max_cyc) begin
            step();
            k++;
            case (which)
                0: hit = mon_dtm_resp_valid;
                1: hit = mon_dm_req_valid;
                2: hit = mon_dm_req_hs;
                3: hit = mon_dm_resp_hs;
                default: hit = mon_req_acc;
            endcase
        end
        if (!hit) check("wait_bound", hit, 1);
    endtask

    task automatic send(input logic [1:0] op, input logic [AB-1:0] addr, input logic [31:0] data);
        int k;
        stim_q.push_back('{addr: addr, op: op, data: data});
        steps_until(4, 20, k);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((req_q.size() > 0 || dm_busy || dtm_req_valid || stim_q.size() > 0) && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_done", n < max_cyc, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        dtm_req_valid = 1'b0; dtm_resp_ready = 1'b0; dm_req_ready = 1'b0;
        dm_resp_valid = 1'b0; dm_resp_resp = '0; dm_resp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        stim_q.delete(); req_q.delete(); dm_exp_q.delete(); exp_q.delete(); force_q.delete();
        dm_busy = 0; exp_ts = 0; hold_resp = 0; hold_req = 0;
        mon_req_acc = 0; mon_dm_resp_hs = 0;
        check("rst_req_ready", dtm_req_ready, 1);
        check("rst_ctrl", {dtm_resp_valid, dm_req_valid, dm_resp_ready, timeout_seen, dtm_resp_resp, dm_req_op, dm_req_addr}, 0);
        check("rst_data", {dtm_resp_data, dm_req_data}, 0);
        reset_n = 1'b1;
    endtask

    // ---------------- sequence ----------------
    initial begin
        int   k;
        int   base;
        dtm_req_addr = '0; dtm_req_op = '0; dtm_req_data = '0;
        cur_req = '0;
        do_reset();

        // NOP answered locally, then a WRITE reaches the DM after it.
        base = dm_iss_cnt;
        send(2'd0, 7'h05, 32'hDEAD_BEEF);
        steps_until(0, 10, k);
        check("nop_latency", k, 2);
        check("nop_no_dm_req", dm_iss_cnt - base, 0);
        force_q.push_back('{dly: 8'd1, resp: 2'd0, data: 32'd0});
        send(2'd2, 7'h10, 32'h1);
        steps_until(1, 10, k);
        check("write_issue_latency", k, 2);
        drain(100);

        // READ 0x11 answered after 3 cycles.
        force_q.push_back('{dly: 8'd3, resp: 2'd0, data: 32'h00C0FFEE});
        send(2'd1, 7'h11, 32'h0);
        steps_until(3, 40, k);
        steps_until(0, 5, k);
        check("dm_resp_latency", k, 1);
        drain(100);
        check("t1_timeout_seen", timeout_seen, 0);

        // Response on exactly the last wait cycle wins over the timeout.
        force_q.push_back('{dly: 8'(TO - 1), resp: 2'd3, data: 32'h1234_5678});
        send(2'd1, 7'h22, 32'h0);
        drain(100);
        check("t5_timeout_seen", timeout_seen, 0);
        check("t5_not_stale", dm_resp_ready, 0);

        // Silent DM: FAILED after TO wait cycles, late answer dropped,
        // next READ issued only afterwards.
        force_q.push_back('{dly: 8'd20, resp: 2'd0, data: 32'hAAAA_5555});
        force_q.push_back('{dly: 8'd1, resp: 2'd0, data: 32'h0BAD_F00D});
        send(2'd1, 7'h33, 32'h0);
        stim_q.push_back('{addr: 7'h34, op: 2'd1, data: 32'h0});
        steps_until(2, 20, k);
        steps_until(0, 40, k);
        check("timeout_latency", k, TO + 1);
        check("t3_timeout_seen", timeout_seen, 1);
        drain(200);

        // Back-pressure: DM not ready, three requests, FIFO fills at two.
        do_reset();
        dm_rdy_en = 0;
        base = acc_cnt;
        repeat (3) force_q.push_back('{dly: 8'd2, resp: 2'd0, data: $urandom});
        repeat (3) stim_q.push_back('{addr: AB'($urandom_range(0, 127)), op: 2'd1, data: 32'h0});
        repeat (8) step();
        check("t4_two_accepted", acc_cnt - base, 2);
        check("t4_ready_low", dtm_req_ready, 0);
        dm_rdy_en = 1;
        k = dm_iss_cnt;
        while (acc_cnt - base < 3 && dm_iss_cnt - k < 10) step();
        check("t4_third_after_issue", (acc_cnt - base == 3) && (dm_iss_cnt - k >= 1), 1);
        drain(300);

        // Reset in WAIT with a full FIFO.
        force_q.push_back('{dly: 8'd40, resp: 2'd0, data: 32'h0});
        repeat (3) stim_q.push_back('{addr: AB'($urandom_range(0, 127)), op: 2'd1, data: $urandom});
        k = 0;
        while (!(dm_busy && !dtm_req_ready) && k < 20) begin step(); k++; end
        check("t6_full_in_wait", {dm_busy, dtm_req_ready}, 2'b10);
        do_reset();
        force_q.push_back('{dly: 8'd2, resp: 2'd0, data: 32'h7777_0001});
        send(2'd1, 7'h44, 32'h0);
        drain(100);
        check("t6_timeout_seen", timeout_seen, 0);

        // Random traffic.
        rand_en = 1;
        rr_pct  = 70;
        repeat (3000) step();
        rand_en = 0;
        drain(400);
        check("end_req_q_empty", req_q.size(), 0);
        check("end_exp_q_empty", exp_q.size(), 0);
        check("end_dm_exp_empty", dm_exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
